// File: rtl/fifo_buf_pkg.sv
// Shared types, defaults and lane selection for the parallel-read FIFO buffer.
// Lane order follows UNPACK_MSB_FIRST_EN: undefined emits LSB lane first, defined emits MSB lane first.
package fifo_buf_pkg;

    localparam int DEF_NUM_BIT  = 4;
    localparam int DEF_PAR_READ = 2;
    localparam int MAX_WORD_W   = 256;

    typedef logic [MAX_WORD_W-1:0] wide_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // idx is the emission order; it is mapped to the physical lane position before shifting.
    function automatic wide_word_t lane_of(input wide_word_t  word,
                                           input int unsigned idx,
                                           input int unsigned num_bit,
                                           input int unsigned par_read);
        int unsigned phys;
        phys = 0;
        if (idx < par_read) begin
`ifdef UNPACK_MSB_FIRST_EN
            phys = par_read - 1 - idx;
`else
            phys = idx;
`endif
        end
        return word >> (phys * num_bit);
    endfunction

endpackage

// File: rtl/unpack_lane_mux.sv
// Combinational lane select: picks the lane of the held word addressed by the emission index.
module unpack_lane_mux
    import fifo_buf_pkg::*;
#(
    parameter int NUM_BIT  = DEF_NUM_BIT,
    parameter int PAR_READ = DEF_PAR_READ,
    parameter int LANE_W   = 1
) (
    input  logic [PAR_READ*NUM_BIT-1:0] word,
    input  logic [LANE_W-1:0]           lane_idx,
    output logic [NUM_BIT-1:0]          lane_data
);

    always_comb begin
        lane_data = NUM_BIT'(lane_of(wide_word_t'(word), 32'(lane_idx), NUM_BIT, PAR_READ));
    end

endmodule

// File: rtl/fifo_read_unpacker.sv
// Pops one PAR_READ*NUM_BIT word from the FIFO and streams it out as PAR_READ NUM_BIT lanes.
// Lane order is selected by UNPACK_MSB_FIRST_EN (see fifo_buf_pkg::lane_of).
module fifo_read_unpacker
    import fifo_buf_pkg::*;
#(
    parameter int NUM_BIT  = DEF_NUM_BIT,
    parameter int PAR_READ = DEF_PAR_READ,
    parameter int TIMEOUT  = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fifo_ready,
    input  logic                        fifo_valid,
    input  logic [PAR_READ*NUM_BIT-1:0] fifo_dout,
    output logic                        fifo_read_en,
    output logic [NUM_BIT-1:0]          out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        rd_err
);

    localparam int LANE_W  = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WORD_W  = PAR_READ * NUM_BIT;

    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PAR_READ - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [LANE_W-1:0]   lane_idx_q, lane_idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                read_en_q, read_en_d;
    logic                out_valid_q, out_valid_d;
    logic                rd_err_q, rd_err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            lane_idx_q  <= '0;
            word_q      <= '0;
            read_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lane_idx_q  <= lane_idx_d;
            word_q      <= word_d;
            read_en_q   <= read_en_d;
            out_valid_q <= out_valid_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Strobes are registered from the next state, so they line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lane_idx_d = lane_idx_q;
        word_d     = word_q;
        rd_err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (fifo_ready) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (fifo_valid) begin
                    word_d     = fifo_dout;
                    lane_idx_d = '0;
                    state_d    = DRAIN;
                end else if (timer_q == TIMER_MAX) begin
                    rd_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    if (lane_idx_q != LAST_LANE) begin
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                    end else begin
                        lane_idx_d = '0;
                        state_d    = fifo_ready ? REQ : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        read_en_d   = (state_d == REQ);
        out_valid_d = (state_d == DRAIN);
    end

    unpack_lane_mux #(
        .NUM_BIT  (NUM_BIT),
        .PAR_READ (PAR_READ),
        .LANE_W   (LANE_W)
    ) u_lane_mux (
        .word      (word_q),
        .lane_idx  (lane_idx_q),
        .lane_data (out_data)
    );

    assign fifo_read_en = read_en_q;
    assign out_valid    = out_valid_q;
    assign rd_err       = rd_err_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_read_unpacker.sv
// Scoreboard bench for fifo_read_unpacker: a FIFO model answers read strobes and queues the expected lanes.
// Lane order follows UNPACK_MSB_FIRST_EN, matching the build of the design.
module tb_fifo_read_unpacker;

    localparam int NUM_BIT  = 4;
    localparam int PAR_READ = 2;
    localparam int TIMEOUT  = 15;
    localparam int W        = NUM_BIT * PAR_READ;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               fifo_ready = 1'b0;
    logic               fifo_valid = 1'b0;
    logic [W-1:0]       fifo_dout = '0;
    logic               out_ready = 1'b0;
    logic               fifo_read_en;
    logic [NUM_BIT-1:0] out_data;
    logic               out_valid;
    logic               busy;
    logic               rd_err;

    fifo_read_unpacker #(
        .NUM_BIT  (NUM_BIT),
        .PAR_READ (PAR_READ),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_ready   (fifo_ready),
        .fifo_valid   (fifo_valid),
        .fifo_dout    (fifo_dout),
        .fifo_read_en (fifo_read_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W-1:0]       wordQ[$];
    logic [NUM_BIT-1:0] expQ[$];
    int                 rdEnCycles[$];
    int                 lastLaneCycles[$];

    bit fifoReadyEn = 0;
    bit oneShotReady = 0;
    bit suppressValid = 0;
    bit randomReady = 0;
    bit prevReadEn = 0;
    bit prevStall = 0;
    bit expectValidNext = 0;
    bit stalledInWord = 0;
    int stallPending = 0;
    int laneInWord = 0;
    int lastAcceptCyc = 0;
    int readEnCount = 0;
    int errPulses = 0;
    int errCycle = -1;
    int holdSeen = 0;
    logic [NUM_BIT-1:0] prevData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected lanes in emission order for one popped word.
    task automatic pushLanes(input logic [W-1:0] word);
        int k;
        for (int i = 0; i < PAR_READ; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
            k = PAR_READ - 1 - i;
`else
            k = i;
`endif
            expQ.push_back(word[k*NUM_BIT +: NUM_BIT]);
        end
    endtask

    // One clock cycle: sample outputs after the edge, run the FIFO model, drive out_ready, score accepts.
    task automatic applyStimulus();
        logic [W-1:0] w;
        @(posedge clk);
        #1;
        cyc++;
        if (expectValidNext) begin
            checkOutput("first_lane_latency", out_valid, 1);
            expectValidNext = 0;
        end
        if (prevStall) begin
            holdSeen++;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", out_data, prevData);
        end
        checkOutput("rden_with_valid", fifo_read_en & out_valid, 0);
        if (rd_err) begin
            errPulses++;
            errCycle = cyc;
        end
        if (fifo_read_en) begin
            readEnCount++;
            rdEnCycles.push_back(cyc);
            if (oneShotReady) fifoReadyEn = 0;
        end

        if (prevReadEn && !suppressValid && wordQ.size() > 0) begin
            w = wordQ.pop_front();
            fifo_valid = 1'b1;
            fifo_dout  = w;
            pushLanes(w);
            expectValidNext = 1;
        end else begin
            fifo_valid = 1'b0;
            fifo_dout  = W'($urandom);
        end
        prevReadEn = fifo_read_en;
        fifo_ready = fifoReadyEn && (wordQ.size() > 0);

        if (out_valid && stallPending > 0) begin
            out_ready = 1'b0;
            stallPending--;
        end else if (randomReady) begin
            out_ready = ($urandom_range(0, 2) != 0);
        end else begin
            out_ready = 1'b1;
        end
        if (out_valid && !out_ready) stalledInWord = 1;

        if (out_valid && out_ready) begin
            if (laneInWord > 0 && !stalledInWord) checkOutput("lane_gap", cyc - lastAcceptCyc, 1);
            if (expQ.size() == 0) checkOutput("lane_extra_count", expQ.size(), 1);
            else checkOutput("lane_data", out_data, expQ.pop_front());
            lastAcceptCyc = cyc;
            laneInWord++;
            if (laneInWord == PAR_READ) begin
                laneInWord = 0;
                stalledInWord = 0;
                lastLaneCycles.push_back(cyc);
            end
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
    endtask

    task automatic runUntilIdle(input string tag, input int maxCycles);
        int n;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while ((busy || expQ.size() > 0 || wordQ.size() > 0 || fifo_read_en) && n < maxCycles);
        checkOutput({tag, "_idle_busy"}, busy, 0);
        checkOutput({tag, "_idle_pending"}, expQ.size(), 0);
    endtask

    task automatic clearBenchState();
        expQ.delete();
        wordQ.delete();
        stallPending = 0;
        prevStall = 0;
        prevReadEn = 0;
        expectValidNext = 0;
        laneInWord = 0;
        stalledInWord = 0;
        fifoReadyEn = 0;
        fifo_ready = 1'b0;
        fifo_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int a;
        int b;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_read_en", fifo_read_en, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd_err", rd_err, 0);
        rst = 1'b0;

        $display("[TB] single pop 8'hB2");
        base = readEnCount;
        wordQ.push_back(8'hB2);
        fifoReadyEn = 1;
        runUntilIdle("single", 50);
        checkOutput("single_read_count", readEnCount - base, 1);

        $display("[TB] backpressure 8'h1C");
        base = holdSeen;
        stallPending = 3;
        wordQ.push_back(8'h1C);
        runUntilIdle("backpressure", 60);
        checkOutput("backpressure_holds", holdSeen - base, 3);

        $display("[TB] back-to-back 8'hFF, 8'h5A");
        base = readEnCount;
        rdEnCycles.delete();
        lastLaneCycles.delete();
        wordQ.push_back(8'hFF);
        wordQ.push_back(8'h5A);
        runUntilIdle("b2b", 80);
        checkOutput("b2b_read_count", readEnCount - base, 2);
        a = (rdEnCycles.size() > 1) ? rdEnCycles[1] : -100;
        b = (lastLaneCycles.size() > 0) ? lastLaneCycles[0] : 0;
        checkOutput("b2b_second_read_gap", a - b, 1);

        $display("[TB] random words with random backpressure");
        randomReady = 1;
        for (int i = 0; i < 6; i++) wordQ.push_back(W'($urandom));
        runUntilIdle("random", 400);
        randomReady = 0;
        checkOutput("no_spurious_rd_err", errPulses, 0);

        $display("[TB] read timeout");
        fifoReadyEn = 0;
        base = readEnCount;
        rdEnCycles.delete();
        suppressValid = 1;
        oneShotReady = 1;
        wordQ.push_back(8'h77);
        fifoReadyEn = 1;
        n = 0;
        while (errPulses == 0 && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("timeout_pulse_seen", errPulses, 1);
        a = (rdEnCycles.size() > 0) ? rdEnCycles[0] : -100;
        checkOutput("timeout_latency", errCycle - (a + 1), 16);
        checkOutput("timeout_busy", busy, 0);
        repeat (3) applyStimulus();
        checkOutput("timeout_single_pulse", errPulses, 1);
        checkOutput("timeout_read_count", readEnCount - base, 1);
        suppressValid = 0;
        oneShotReady = 0;
        clearBenchState();
        repeat (2) applyStimulus();

        $display("[TB] reset during drain");
        stallPending = 100;
        wordQ.push_back(8'h3D);
        fifoReadyEn = 1;
        n = 0;
        while (!out_valid && n < 30) begin
            applyStimulus();
            n++;
        end
        checkOutput("rst_pre_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_drain_read_en", fifo_read_en, 0);
        checkOutput("rst_drain_out_valid", out_valid, 0);
        checkOutput("rst_drain_out_data", out_data, 0);
        checkOutput("rst_drain_busy", busy, 0);
        checkOutput("rst_drain_rd_err", rd_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearBenchState();
        repeat (4) applyStimulus();
        checkOutput("rst_after_busy", busy, 0);
        checkOutput("rst_after_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
